// File: rtl/imem_prog_loader_if.sv
// ---------------------------------------------------------------------------
// imem_prog_loader_if
//   Bundles the two buses of the program loader:
//     - the instruction stream (in_valid / in_data / in_ready handshake)
//     - the imem write port (imem_addr / imem_wdata / imem_we)
//   Modports:
//     master : host side, which feeds instructions and observes imem writes
//     slave  : the loader, which accepts instructions and drives the imem port
// ---------------------------------------------------------------------------
interface imem_prog_loader_if #(
    parameter int INSN_LEN = 32,
    parameter int ADDR_W   = 9
);
    logic                    in_valid;
    logic [INSN_LEN-1:0]     in_data;
    logic                    in_ready;
    logic [ADDR_W-1:0]       imem_addr;
    logic [4*INSN_LEN-1:0]   imem_wdata;
    logic                    imem_we;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  imem_addr,
        input  imem_wdata,
        input  imem_we
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output imem_addr,
        output imem_wdata,
        output imem_we
    );
endinterface

// File: rtl/imem_prog_loader.sv
// ---------------------------------------------------------------------------
// imem_prog_loader
//   Write-side companion of the 4-way instruction memory. Collects 32-bit
//   instructions from a valid/ready stream, packs four of them per 128-bit
//   fetch line (first instruction in the low bits) and writes each line to
//   base_addr + line index, wrapping modulo 2**ADDR_W. The core is held
//   stalled while a load is in flight.
// Ports:
//   clk        clock, all state on the rising edge
//   reset_x    asynchronous active-low reset
//   start      begin a load (sampled only when idle)
//   base_addr  first line address, captured on an accepted start
//   num_lines  number of lines to write, captured on an accepted start
//   flush      zero-pad and write the current partial line, then finish
//   bus        instruction stream + imem write port (slave side)
//   core_hold  stall request to the core while loading
//   done       one-cycle pulse when the load completes
// ---------------------------------------------------------------------------
module imem_prog_loader #(
    parameter int INSN_LEN = 32,
    parameter int ADDR_W   = 9
) (
    input  logic                  clk,
    input  logic                  reset_x,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       num_lines,
    input  logic                  flush,
    imem_prog_loader_if.slave     bus,
    output logic                  core_hold,
    output logic                  done
);

    localparam int LINE_W = 4 * INSN_LEN;
    localparam logic [ADDR_W:0] ONE_LINE = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        FIN
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W:0]     num_q;
    logic [ADDR_W:0]     line_cnt;
    logic [1:0]          slot_cnt;
    logic [LINE_W-1:0]   line_buf;
    logic                flush_q;

    logic                accept;
    logic                line_full;
    logic                last_line;
    logic [LINE_W-1:0]   merged;

    // The line as it will look after this cycle's accepted word (if any).
    // Slots not yet filled stay zero, so a flushed line is already padded.
    always_comb begin
        accept    = bus.in_valid && bus.in_ready;
        merged    = line_buf;
        if (accept) begin
            merged[slot_cnt*INSN_LEN +: INSN_LEN] = bus.in_data;
        end
        line_full = accept && (slot_cnt == 2'd3);
        last_line = (line_cnt + ONE_LINE) == num_q;
    end

    // Load sequencer. All outputs are registered; they are set on the edge
    // that enters the state in which they must be visible.
    // FIN: done/core_hold are already updated when entered from a write or a
    // flush; when entered straight from IDLE (num_lines == 0) one FIN cycle
    // passes with core_hold still high before done is raised.
    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state          <= IDLE;
            base_q         <= '0;
            num_q          <= '0;
            line_cnt       <= '0;
            slot_cnt       <= '0;
            line_buf       <= '0;
            flush_q        <= 1'b0;
            bus.in_ready   <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            bus.imem_we    <= 1'b0;
            core_hold      <= 1'b0;
            done           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q    <= base_addr;
                        num_q     <= num_lines;
                        line_cnt  <= '0;
                        slot_cnt  <= '0;
                        line_buf  <= '0;
                        flush_q   <= 1'b0;
                        core_hold <= 1'b1;
                        if (num_lines == '0) begin
                            state <= FIN;
                        end else begin
                            state        <= COLLECT;
                            bus.in_ready <= 1'b1;
                        end
                    end
                end

                COLLECT: begin
                    if (accept) begin
                        line_buf <= merged;
                        slot_cnt <= slot_cnt + 2'd1;
                    end
                    if (line_full || (flush && (accept || slot_cnt != 2'd0))) begin
                        // Full line, or a flush with at least one word held.
                        state          <= WRITE;
                        bus.in_ready   <= 1'b0;
                        bus.imem_we    <= 1'b1;
                        bus.imem_wdata <= merged;
                        bus.imem_addr  <= base_q + line_cnt[ADDR_W-1:0];
                        line_buf       <= '0;
                        slot_cnt       <= '0;
                        flush_q        <= flush;
                    end else if (flush) begin
                        // Flush on an empty line: nothing to write.
                        state        <= FIN;
                        bus.in_ready <= 1'b0;
                        done         <= 1'b1;
                        core_hold    <= 1'b0;
                    end
                end

                WRITE: begin
                    bus.imem_we <= 1'b0;
                    line_cnt    <= line_cnt + ONE_LINE;
                    if (flush_q || last_line) begin
                        state     <= FIN;
                        done      <= 1'b1;
                        core_hold <= 1'b0;
                    end else begin
                        state        <= COLLECT;
                        bus.in_ready <= 1'b1;
                    end
                end

                FIN: begin
                    if (done) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done      <= 1'b1;
                        core_hold <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
